seq_restoring_divider: RTL
==========================

Name: seq_restoring_divider

Overview:
Multi-cycle integer divider that performs the inverse operation of the datapath adders by repeated shift-and-subtract.
- Produces one quotient bit per clock using a single WIDTH+1-bit subtractor.
- Sits beside the ALU adder as the divide/remainder execution unit.
- Start/busy/done handshake toward the issuing controller.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (must be >= 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  operation in flight; start ignored while high
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered quotient, held until next completion
remainder  output  WIDTH  registered remainder, held until next completion
div_by_zero  output  1  registered flag for the last completed op
overflow  output  1  registered flag for the last completed op: signed (-2^(WIDTH-1)) / (-1)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, quotient, remainder, div_by_zero, overflow all 0; iteration counter 0. Deassertion takes effect at the next clk edge.
- Reset mid-operation: aborts immediately, no done pulse, outputs return to 0.
- States: IDLE, CALC, FIX.
- IDLE: on edge k with start=1:
  - Latch operand magnitudes: in signed mode, negate negative operands; in unsigned mode, pass through.
  - Latch signed_op, the quotient sign (dividend_msb XOR divisor_msb, signed mode only) and the remainder sign (dividend_msb, signed mode only).
  - Clear the partial remainder; load count=WIDTH.
  - busy<=1.
  - divisor==0 -> FIX with zero flag set; otherwise -> CALC.
- CALC, one iteration per edge (edges k+1 .. k+WIDTH):
  - Shift the {partial remainder, quotient} pair left by 1.
  - Trial-subtract the divisor magnitude at WIDTH+1 bits.
  - Non-negative result: keep the difference, set quotient LSB=1. Negative result: restore, LSB=0.
  - count--. Leave for FIX when count reaches 0 on that edge.
- FIX (edge k+WIDTH+1 normal; edge k+1 for divide-by-zero):
  - Apply sign correction: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register quotient/remainder/flags; done<=1; busy<=0; -> IDLE.
- done: high for exactly one cycle after the FIX edge; cleared on the next edge unconditionally.
- Latency (start edge to done-asserting edge): WIDTH+1 edges normally (33 at default); 1 edge for divide-by-zero.
- Back-to-back: start may be high in the cycle done is high; it is accepted, since state is IDLE.
- start while busy=1: ignored, no queuing.
- Operand inputs may change freely after the acceptance edge.
- Divide-by-zero:
  - quotient = all ones (unsigned max, or -1 signed); remainder = dividend unchanged.
  - div_by_zero=1, overflow=0.
- Signed overflow (dividend=1 followed by WIDTH-1 zeros, divisor = all ones, signed_op=1):
  - Computed normally: quotient = 1 followed by WIDTH-1 zeros, remainder = 0.
  - overflow=1, div_by_zero=0.
- Flags clear to 0 on any completion that does not raise them.
- Invariants, checked on each done (excluding div-by-zero and overflow):
  - dividend == quotient*divisor + remainder (mod 2^WIDTH).
  - |remainder| < |divisor|.
  - Remainder is zero or has the dividend's sign.
- Outputs change only on FIX edges or reset.

Test Plan:
- Unsigned 100 / 7, start at edge 0 -> busy high for 33 cycles; done pulse after edge 33; quotient=14, remainder=2, flags 0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Unsigned same operands -> quotient=0x7FFFFFFC, remainder=1.
- 5 / 0 unsigned -> done after edge 1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9 / 3 -> quotient=3, remainder=0, div_by_zero=0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1. Unsigned same operands -> quotient=0, remainder=0x80000000, overflow=0.
- start pulsed with 50/5 at edge 10 of a 100/7 op -> ignored; result 14/2. start in the done cycle with 50/5 -> accepted, quotient=10 after 33 more edges.
- rst_n low at cycle 15 of an op -> all outputs 0 immediately, no done. New op 1/1 after release -> quotient=1, remainder=0.

Source files
------------

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus between an issuing
// controller and the sequential restoring divider.
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock through a single
// WIDTH+1-bit trial subtractor, with sign fix-up for two's-complement mode.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_out_q, ovf_out_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic [WIDTH-1:0] zero_rem;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_out_d   = ovf_out_q;

        // quo_q starts as the dividend magnitude and is shifted out MSB-first
        shifted = {prem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_q};

        dividend_mag = (bus.signed_op && bus.dividend[WIDTH-1])
                       ? WIDTH'(WIDTH'(0) - bus.dividend) : bus.dividend;
        divisor_mag  = (bus.signed_op && bus.divisor[WIDTH-1])
                       ? WIDTH'(WIDTH'(0) - bus.divisor) : bus.divisor;
        quo_fixed    = q_neg_q ? WIDTH'(WIDTH'(0) - quo_q) : quo_q;
        rem_fixed    = r_neg_q ? WIDTH'(WIDTH'(0) - prem_q) : prem_q;
        // Divide-by-zero never shifts, so re-signing the magnitude restores the dividend
        zero_rem     = r_neg_q ? WIDTH'(WIDTH'(0) - quo_q) : quo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvsr_d  = divisor_mag;
                    quo_d   = dividend_mag;
                    prem_d  = '0;
                    count_d = CW'(WIDTH);
                    q_neg_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    r_neg_d = bus.signed_op & bus.dividend[WIDTH-1];
                    zero_d  = (bus.divisor == '0);
                    ovf_d   = bus.signed_op
                              && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                              && (bus.divisor == '1);
                    busy_d  = 1'b1;
                    state_d = (bus.divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = zero_rem;
                end else begin
                    quotient_d  = quo_fixed;
                    remainder_d = rem_fixed;
                end
                dbz_d     = zero_q;
                ovf_out_d = ovf_q & ~zero_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_out_q;
endmodule
